// File: rtl/rs_latch_driver_if.sv
// Register-write side of the RS latch driver: request, data and status.
interface rs_latch_driver_if #(parameter int WIDTH = 4);
  logic             req;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             err;

  modport master (output req, wr_data, input busy, done, err);
  modport slave  (input req, wr_data, output busy, done, err);
endinterface

// File: rtl/rs_latch_driver.sv
// Break-before-make R/S/gate sequencer for a bank of gated RS latches,
// with synchronized readback verify and bounded retry.
//
// state  | meaning
// IDLE   | waiting for req; err holds the last result
// SETUP  | R/S driven from dreg, gate still closed
// PULSE  | gate open for PULSE_CYCLES
// HOLD   | gate closed, R/S still held
// SETTLE | R/S released, waiting for q to cross the synchronizer
// VERIFY | compare synchronized q with dreg, retry or finish
module rs_latch_driver #(
  parameter int WIDTH         = 4,
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int MAX_RETRY     = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  rs_latch_driver_if.slave       host,
  output logic                   gate_out,
  output logic [WIDTH-1:0]       r_out,
  output logic [WIDTH-1:0]       s_out,
  input  logic [WIDTH-1:0]       q_in
);

  localparam int TMAX = (PULSE_CYCLES > SETTLE_CYCLES + 2) ? PULSE_CYCLES : SETTLE_CYCLES + 2;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, SETTLE, VERIFY} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] dreg, dreg_n;
  logic [TW-1:0]    tmr, tmr_n;
  logic [RW-1:0]    rcnt, rcnt_n;
  logic             busy_q, busy_n, done_q, done_n, err_q, err_n;
  logic             gate_n;
  logic [WIDTH-1:0] r_n, s_n;
  logic [WIDTH-1:0] q_s1, q_s2;
  logic             drive;

  assign host.busy = busy_q;
  assign host.done = done_q;
  assign host.err  = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      dreg     <= '0;
      tmr      <= '0;
      rcnt     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      gate_out <= 1'b0;
      r_out    <= '0;
      s_out    <= '0;
      q_s1     <= '0;
      q_s2     <= '0;
    end else begin
      state    <= state_n;
      dreg     <= dreg_n;
      tmr      <= tmr_n;
      rcnt     <= rcnt_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      err_q    <= err_n;
      gate_out <= gate_n;
      r_out    <= r_n;
      s_out    <= s_n;
      q_s1     <= q_in;
      q_s2     <= q_s1;
    end
  end

  always_comb begin
    state_n = state;
    dreg_n  = dreg;
    tmr_n   = tmr;
    rcnt_n  = rcnt;
    busy_n  = busy_q;
    done_n  = 1'b0;
    err_n   = err_q;
    case (state)
      IDLE: begin
        if (host.req) begin
          dreg_n  = host.wr_data;
          rcnt_n  = '0;
          err_n   = 1'b0;
          busy_n  = 1'b1;
          state_n = SETUP;
        end
      end
      SETUP: begin
        tmr_n   = TW'(PULSE_CYCLES - 1);
        state_n = PULSE;
      end
      PULSE: begin
        if (tmr == '0) state_n = HOLD;
        else           tmr_n   = tmr - TW'(1);
      end
      HOLD: begin
        tmr_n   = TW'(SETTLE_CYCLES + 1);
        state_n = SETTLE;
      end
      SETTLE: begin
        if (tmr == '0) state_n = VERIFY;
        else           tmr_n   = tmr - TW'(1);
      end
      VERIFY: begin
        if (q_s2 == dreg) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else if (rcnt < RW'(MAX_RETRY)) begin
          rcnt_n  = rcnt + RW'(1);
          state_n = SETUP;
        end else begin
          done_n  = 1'b1;
          err_n   = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs follow the next state so they are registered yet aligned with it.
    drive  = (state_n == SETUP) || (state_n == PULSE) || (state_n == HOLD);
    gate_n = (state_n == PULSE);
    s_n    = drive ? dreg_n  : '0;
    r_n    = drive ? ~dreg_n : '0;
  end

endmodule

// File: tb/tb_rs_latch_driver.sv
// Scoreboard bench for rs_latch_driver with a behavioural latch bank model.
module tb_rs_latch_driver;
  localparam int W = 4;

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    int           lat;
    int           pulses;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic gate_out;
  logic [W-1:0] r_out, s_out, q_in;
  logic [W-1:0] q_model = '0;
  logic [W-1:0] stuck_mask = '0, stuck_val = '0, once_mask = '0;
  logic [W-1:0] mask_eff;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int txn_pulses = 0;
  int gate_len = 0;
  exp_t sb[$];

  rs_latch_driver_if #(.WIDTH(W)) bus ();

  rs_latch_driver #(.WIDTH(W), .PULSE_CYCLES(2), .SETTLE_CYCLES(1), .MAX_RETRY(2)) dut (
    .clk(clk), .reset_n(reset_n), .host(bus),
    .gate_out(gate_out), .r_out(r_out), .s_out(s_out), .q_in(q_in));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Latch bank: transparent while gate is high, S wins over R only in the model.
  always @(negedge clk) begin
    if (gate_out) begin
      for (int i = 0; i < W; i++)
        if (s_out[i]) q_model[i] <= 1'b1;
        else if (r_out[i]) q_model[i] <= 1'b0;
    end
  end
  assign mask_eff = stuck_mask | ((txn_pulses < 2) ? once_mask : '0);
  assign q_in = (q_model & ~mask_eff) | (stuck_val & mask_eff);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pop on done.
  logic gate_p = 1'b0, done_p = 1'b0, busy_p = 1'b0, rst_p = 1'b0;
  logic [W-1:0] r_p = '0, s_p = '0;
  always @(negedge clk) begin
    exp_t e;
    chk("rs_exclusive", {28'd0, r_out & s_out}, 32'd0);
    if (reset_n && rst_p) begin
      if (bus.busy && !busy_p) begin
        acc_cyc = cyc;
        txn_pulses = 0;
      end
      if (gate_out && !gate_p) begin
        txn_pulses++;
        gate_len = 0;
        chk("rs_stable_before_gate", {24'd0, r_out, s_out}, {24'd0, r_p, s_p});
        chk("rs_valid_before_gate", {28'd0, r_p ^ s_p}, 32'hF);
      end
      if (gate_out) begin
        gate_len++;
        if (sb.size() > 0) begin
          chk("s_during_gate", {28'd0, s_out}, {28'd0, sb[0].data});
          chk("r_during_gate", {28'd0, r_out}, {28'd0, ~sb[0].data});
        end
      end
      if (!gate_out && gate_p) begin
        chk("rs_stable_after_gate", {24'd0, r_out, s_out}, {24'd0, r_p, s_p});
        chk("gate_width", gate_len, 2);
      end
      if (bus.done) begin
        chk("done_single_cycle", {31'd0, done_p}, 32'd0);
        chk("busy_low_at_done", {31'd0, bus.busy}, 32'd0);
        if (sb.size() == 0) begin
          chk("done_expected", 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          chk("done_err", {31'd0, bus.err}, {31'd0, e.err});
          chk("done_latency", cyc - acc_cyc, e.lat);
          chk("gate_pulses", txn_pulses, e.pulses);
        end
      end
    end
    gate_p = gate_out; done_p = bus.done; busy_p = bus.busy;
    rst_p = reset_n; r_p = r_out; s_p = s_out;
  end

  task automatic wait_busy(input logic lvl, input int budget, input string name);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (bus.busy === lvl) ok = 1;
    end
    if (!ok) chk(name, 32'd0, 32'd1);
  endtask

  task automatic do_write(input logic [W-1:0] d, input logic e, input int lat, input int pulses);
    exp_t x;
    x.data = d; x.err = e; x.lat = lat; x.pulses = pulses;
    sb.push_back(x);
    @(negedge clk);
    bus.req = 1'b1;
    bus.wr_data = d;
    wait_busy(1'b1, 5, "accept_timeout");
    chk("err_cleared_on_accept", {31'd0, bus.err}, 32'd0);
    bus.req = 1'b0;
    wait_busy(1'b0, 60, "complete_timeout");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x;
    bit seen;
    bus.req = 1'b0;
    bus.wr_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_err", {31'd0, bus.err}, 32'd0);
    chk("reset_gate", {31'd0, gate_out}, 32'd0);
    chk("reset_rs", {24'd0, r_out, s_out}, 32'd0);
    reset_n = 1'b1;

    // 1: abort mid-PULSE with async reset, then a normal write.
    @(negedge clk);
    bus.req = 1'b1; bus.wr_data = 4'h5;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      bus.req = 1'b0;
      if (gate_out) seen = 1;
    end
    chk("gate_reached", {31'd0, seen}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_gate", {31'd0, gate_out}, 32'd0);
    chk("abort_rs", {24'd0, r_out, s_out}, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    do_write(4'hA, 1'b0, 8, 1);

    // 2: basic write.
    do_write(4'b1010, 1'b0, 8, 1);
    chk("q_after_basic", {28'd0, q_in}, 32'hA);

    // 3: random writes.
    for (int n = 0; n < 200; n++) do_write(W'($urandom), 1'b0, 8, 1);

    // 4: bit0 stuck for the first attempt only.
    @(negedge clk);
    bus.wr_data = 4'h0;
    do_write(4'h0, 1'b0, 8, 1);
    once_mask = 4'h1; stuck_val = 4'h0;
    do_write(4'h1, 1'b0, 16, 2);
    once_mask = 4'h0;

    // 5: bit3 stuck low permanently.
    stuck_mask = 4'h8; stuck_val = 4'h0;
    do_write(4'h8, 1'b1, 24, 3);
    repeat (5) @(negedge clk);
    chk("err_held_idle", {31'd0, bus.err}, 32'd1);
    stuck_mask = 4'h0;
    do_write(4'h3, 1'b0, 8, 1);
    chk("err_after_next", {31'd0, bus.err}, 32'd0);

    // 6: back-to-back with req held, then noise while busy.
    x.err = 1'b0; x.lat = 8; x.pulses = 1;
    x.data = 4'h3; sb.push_back(x);
    x.data = 4'hC; sb.push_back(x);
    @(negedge clk);
    bus.req = 1'b1; bus.wr_data = 4'h3;
    wait_busy(1'b1, 5, "b2b_accept1");
    bus.wr_data = 4'hC;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    chk("b2b_first_done", {31'd0, seen}, 32'd1);
    @(negedge clk);
    chk("b2b_no_gap", {31'd0, bus.busy}, 32'd1);
    bus.req = 1'b0; bus.wr_data = 4'h5;
    repeat (2) @(negedge clk);
    bus.req = 1'b1; bus.wr_data = 4'hF;
    @(negedge clk);
    bus.req = 1'b0; bus.wr_data = 4'h6;
    wait_busy(1'b0, 20, "b2b_complete");
    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("no_extra_busy", {31'd0, bus.busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
